// File: rtl/md_ctrl.sv
// Multiply/divide sequencer for the E stage: decodes HI/LO-class ops, runs a fixed-latency
// busy counter, commits HI/LO and requests D-stage stalls. Divide support is under `MD_DIV_EN.
module md_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir_e,
    input  logic [31:0] ir_d,
    input  logic [31:0] rs_e,
    input  logic [31:0] rt_e,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;
    localparam logic [4:0] MUL_LAT = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LAT = 5'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        uns_q, uns_d;

    logic       sp_e, sp_d, is_mul_e, is_div_e, hl_d;
    logic [5:0] fe, fd;

    assign sp_e = (ir_e[31:26] == 6'd0);
    assign sp_d = (ir_d[31:26] == 6'd0);
    assign fe   = ir_e[5:0];
    assign fd   = ir_d[5:0];

    // mult/multu share funct[5:1]=01100, div/divu share 01101, moves share funct[5:2]=0100
    assign is_mul_e = sp_e && (fe[5:1] == 5'b01100);
`ifdef MD_DIV_EN
    assign is_div_e = sp_e && (fe[5:1] == 5'b01101);
    assign hl_d     = sp_d && ((fd[5:2] == 4'b0100) || (fd[5:2] == 4'b0110));
`else
    assign is_div_e = 1'b0;
    assign hl_d     = sp_d && ((fd[5:2] == 4'b0100) || (fd[5:1] == 5'b01100));
`endif

    assign busy     = (state_q == RUN);
    assign start    = (is_mul_e || is_div_e) && !busy;
    assign stall_md = (start || busy) && hl_d;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_out   = (sp_e && fe == F_MFHI) ? hi_q : lo_q;

    // One 64x64 multiplier covers both flavours: sign-extend only for the signed op.
    logic [63:0] prod;
    always_comb begin
        prod = {{32{!uns_q && op_a_q[31]}}, op_a_q} * {{32{!uns_q && op_b_q[31]}}, op_b_q};
    end

`ifdef MD_DIV_EN
    logic        div_q, div_d;
    logic [31:0] quo, rem;
    always_comb begin
        quo = '0;
        rem = '0;
        if (op_b_q != 32'd0) begin
            if (uns_q) begin
                quo = op_a_q / op_b_q;
                rem = op_a_q % op_b_q;
            end else begin
                quo = $unsigned($signed(op_a_q) / $signed(op_b_q));
                rem = $unsigned($signed(op_a_q) % $signed(op_b_q));
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        uns_d   = uns_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MD_DIV_EN
        div_d   = div_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_a_d  = rs_e;
                    op_b_d  = rt_e;
                    uns_d   = fe[0];
                    cnt_d   = is_div_e ? DIV_LAT : MUL_LAT;
`ifdef MD_DIV_EN
                    div_d   = is_div_e;
`endif
                end else if (sp_e && fe == F_MTHI) begin
                    hi_d = rs_e;
                end else if (sp_e && fe == F_MTLO) begin
                    lo_d = rs_e;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = IDLE;
`ifdef MD_DIV_EN
                    if (div_q) begin
                        // divide by zero still burns the full latency but leaves HI/LO alone
                        if (op_b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
`else
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            uns_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MD_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            uns_q   <= uns_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MD_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    logic unused_ir;
    assign unused_ir = ^{ir_e[25:6], ir_d[25:6]};
endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: vector table, hand-written corner sequences and a
// randomized run against a cycle-level behavioural model of HI/LO and the busy window.
module tb_md_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MD_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif
    localparam logic [5:0] F_MFHI = 6'b010000, F_MTHI = 6'b010001, F_MFLO = 6'b010010,
                           F_MTLO = 6'b010011, F_MULT = 6'b011000, F_MULTU = 6'b011001,
                           F_DIV  = 6'b011010, F_DIVU = 6'b011011;
    localparam logic [31:0] NOP = 32'h0;

    logic clk, reset;
    logic [31:0] ir_e, ir_d, rs_e, rt_e;
    logic start, busy, stall_md;
    logic [31:0] hi, lo, md_out;

    md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .ir_e(ir_e), .ir_d(ir_d), .rs_e(rs_e), .rt_e(rt_e),
        .start(start), .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo), .md_out(md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, passed = 0;

    // reference model: HI/LO, remaining busy cycles and the pending result
    int left;
    logic [31:0] mhi, mlo, phi, plo;
    bit pw;
    logic last_busy, last_stall, last_start;
    logic [31:0] last_hi, last_lo, last_md;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] f);
        logic [19:0] mid;
        mid = 20'($urandom);
        return {6'd0, mid, f};
    endfunction

    function automatic bit is_fn(input logic [31:0] w, input logic [5:0] f);
        return (w[31:26] == 6'd0) && (w[5:0] == f);
    endfunction

    function automatic bit md_op(input logic [31:0] w);
        return is_fn(w, F_MULT) || is_fn(w, F_MULTU) ||
               (DIV_ON && (is_fn(w, F_DIV) || is_fn(w, F_DIVU)));
    endfunction

    function automatic bit hl_class(input logic [31:0] w);
        return md_op(w) || is_fn(w, F_MFHI) || is_fn(w, F_MTHI) ||
               is_fn(w, F_MFLO) || is_fn(w, F_MTLO);
    endfunction

    task automatic model_issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sp, q, r;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pw = 1'b1;
        if (is_fn(w, F_MULT)) begin
            sp = sa * sb; phi = sp[63:32]; plo = sp[31:0]; left = MC;
        end else if (is_fn(w, F_MULTU)) begin
            up = {32'd0, a} * {32'd0, b}; phi = up[63:32]; plo = up[31:0]; left = MC;
        end else begin
            left = DC;
            if (b == 32'd0) pw = 1'b0;
            else if (is_fn(w, F_DIV)) begin
                q = sa / sb; r = sa % sb; plo = q[31:0]; phi = r[31:0];
            end else begin
                plo = a / b; phi = a % b;
            end
        end
    endtask

    // one clock cycle: drive, check every output against the model mid-cycle, advance model
    task automatic cyc(input logic [31:0] ie, input logic [31:0] id,
                       input logic [31:0] a, input logic [31:0] b);
        bit es, eb;
        ir_e = ie; ir_d = id; rs_e = a; rt_e = b;
        @(negedge clk);
        eb = (left != 0);
        es = !eb && md_op(ie);
        chk("start", {31'd0, start}, {31'd0, es});
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("stall_md", {31'd0, stall_md}, {31'd0, (es || eb) && hl_class(id)});
        chk("hi", hi, mhi);
        chk("lo", lo, mlo);
        chk("md_out", md_out, is_fn(ie, F_MFHI) ? mhi : mlo);
        last_busy = busy; last_stall = stall_md; last_start = start;
        last_hi = hi; last_lo = lo; last_md = md_out;
        if (!reset) begin
            if (left > 0) begin
                left--;
                if (left == 0 && pw) begin mhi = phi; mlo = plo; end
            end else if (es) model_issue(ie, a, b);
            else if (is_fn(ie, F_MTHI)) mhi = a;
            else if (is_fn(ie, F_MTLO)) mlo = a;
        end
        @(posedge clk);
        #1;
    endtask

    // issue one op, then idle until busy drops; n = number of busy cycles seen
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        cyc(mk(f), NOP, a, b);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(NOP, NOP, 32'd0, 32'd0);
            if (!last_busy) break;
            n++;
        end
        if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
    endtask

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a, b, ehi, elo;
    } vec_t;
    vec_t tbl[7];

    initial begin
        int n, exp_n, scnt;
        logic [31:0] w, a, b;
        bit act;

        tbl[0] = '{F_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{F_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
        tbl[2] = '{F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        tbl[4] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        tbl[5] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        tbl[6] = '{F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

        reset = 1'b1; ir_e = NOP; ir_d = NOP; rs_e = '0; rt_e = '0;
        left = 0; mhi = '0; mlo = '0; phi = '0; plo = '0; pw = 1'b0;
        #2;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_stall", {31'd0, stall_md}, 32'd0);
        chk("rst_md_out", md_out, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // vector table, HI/LO preloaded so a suppressed op is visible
        foreach (tbl[i]) begin
            cyc(mk(F_MTHI), NOP, 32'hA5A5A5A5, 32'd0);
            cyc(mk(F_MTLO), NOP, 32'h5A5A5A5A, 32'd0);
            act = (tbl[i].f == F_MULT || tbl[i].f == F_MULTU) || DIV_ON;
            exp_n = !act ? 0 : ((tbl[i].f == F_DIV || tbl[i].f == F_DIVU) ? DC : MC);
            run_op(tbl[i].f, tbl[i].a, tbl[i].b, n);
            chk($sformatf("vec%0d_cycles", i), 32'(n), 32'(exp_n));
            chk($sformatf("vec%0d_hi", i), last_hi, act ? tbl[i].ehi : 32'hA5A5A5A5);
            chk($sformatf("vec%0d_lo", i), last_lo, act ? tbl[i].elo : 32'h5A5A5A5A);
        end

        // divide by zero keeps HI/LO and still takes the full latency
        cyc(mk(F_MTHI), NOP, 32'h11111111, 32'd0);
        cyc(mk(F_MTLO), NOP, 32'h22222222, 32'd0);
        run_op(F_DIV, 32'd1234, 32'd0, n);
        chk("div0_cycles", 32'(n), DIV_ON ? 32'(DC) : 32'd0);
        chk("div0_hi", last_hi, 32'h11111111);
        chk("div0_lo", last_lo, 32'h22222222);

        // mult with mflo held in D; a second mult in E during RUN must be ignored
        scnt = 0;
        cyc(mk(F_MULT), mk(F_MFLO), 32'd3, 32'd5);
        if (last_stall) scnt++;
        for (int k = 0; k < MC; k++) begin
            cyc(mk(F_MULT), mk(F_MFLO), 32'd100, 32'd100);
            if (last_stall) scnt++;
        end
        chk("stall_cycles", 32'(scnt), 32'(MC + 1));
        cyc(mk(F_MFLO), NOP, 32'd0, 32'd0);
        chk("mflo_after_mult", last_md, 32'd15);
        chk("busy_after_mult", {31'd0, last_busy}, 32'd0);
        chk("stall_released", {31'd0, last_stall}, 32'd0);
        cyc(mk(F_MFHI), NOP, 32'd0, 32'd0);
        chk("mfhi_after_mult", last_md, 32'd0);
        cyc(mk(F_MTHI), NOP, 32'hCAFEF00D, 32'd0);
        cyc(mk(F_MFHI), NOP, 32'd0, 32'd0);
        chk("mthi_then_mfhi", last_md, 32'hCAFEF00D);

        // asynchronous reset in the middle of a mult discards the result
        cyc(mk(F_MTHI), NOP, 32'h33333333, 32'd0);
        cyc(mk(F_MTLO), NOP, 32'h44444444, 32'd0);
        cyc(mk(F_MULT), NOP, 32'd9, 32'd9);
        cyc(NOP, NOP, 32'd0, 32'd0);
        cyc(NOP, NOP, 32'd0, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        left = 0; mhi = '0; mlo = '0;
        cyc(NOP, NOP, 32'd0, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) cyc(NOP, NOP, 32'd0, 32'd0);
        chk("arst_no_commit_hi", last_hi, 32'd0);
        chk("arst_no_commit_lo", last_lo, 32'd0);

        // randomized instruction stream against the model
        for (int k = 0; k < 400; k++) begin
            logic [5:0] fs[8];
            logic [31:0] wd;
            fs = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU};
            case ($urandom_range(0, 9))
                8:       w = {6'd0, 20'($urandom), 6'b100001};
                9:       w = {6'h23, 20'($urandom), fs[$urandom_range(0, 7)]};
                default: w = mk(fs[$urandom_range(0, 7)]);
            endcase
            wd = ($urandom_range(0, 2) == 0) ? {6'h08, 26'($urandom)} : mk(fs[$urandom_range(0, 7)]);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            cyc(w, wd, a, b);
        end
        for (int k = 0; k < DC + 2; k++) cyc(NOP, NOP, 32'd0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide sequencing unit for the pipelined MIPS core. It sits in the E stage beside the ALU and takes its operands from the E-stage rs/rt bypass selectors. It decodes mult/multu/div/divu/mthi/mtlo/mfhi/mflo from the E-stage instruction, runs a fixed-latency busy counter, and commits HI/LO. It also drives the D-stage stall request that holds any HI/LO-class instruction while the unit is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu; legal 1..31
- DIV_CYCLES, 10, busy cycles for div/divu; legal 1..31

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- ir_e  input  32  E-stage instruction word
- ir_d  input  32  D-stage instruction word, used for stall detection only
- rs_e  input  32  forwarded rs operand (E stage)
- rt_e  input  32  forwarded rt operand (E stage)
- start  output  1  combinational; high while ir_e is a mult/multu/div/divu and busy==0
- busy  output  1  registered; high while an operation is in flight
- stall_md  output  1  combinational stall request to the D/E pipeline registers
- hi  output  32  HI register
- lo  output  32  LO register
- md_out  output  32  combinational; hi when ir_e is mfhi, otherwise lo

## Operation
- Decode applies only when ir_e[31:26]==6'b000000. Funct codes: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
- Two states:
  - IDLE (busy=0).
  - RUN (busy=1, 5-bit cnt).
- IDLE -> RUN on start:
  - latch rs_e and rt_e into op_a/op_b.
  - latch the op kind.
  - load cnt with MULT_CYCLES or DIV_CYCLES.
- RUN: cnt decrements each cycle. On the edge where cnt==1:
  - write HI/LO.
  - return to IDLE.
- mult: {hi,lo} = signed 64-bit product. multu: {hi,lo} = unsigned 64-bit product.
- div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend. divu: unsigned quotient and remainder.
- Divide by zero: the operation still occupies DIV_CYCLES, and HI/LO are left unchanged.
- mthi/mtlo in E while busy==0: write rs_e into hi/lo at the clock edge. The same instruction while busy==1 cannot occur because stall_md prevents it. If it occurs anyway, it is ignored.
- start is forced low while busy==1. A md op in E during RUN is ignored, with no restart and no corruption.
- stall_md = (start | busy) & (ir_d is any of the 8 HI/LO-class instructions).
- Reset at any time, including mid-RUN:
  - hi=0, lo=0, busy=0, cnt=0, state=IDLE.
  - The in-flight result is discarded.

## Timing
- Reset values:
  - hi=0, lo=0, busy=0.
  - start, stall_md and md_out follow their combinational definitions (start=0, and md_out=0 once ir_e decodes to nothing).
- Op in E during cycle T with busy==0:
  - start=1 in T.
  - busy=1 in T+1 through T+N, where N is the configured latency.
  - HI/LO are updated at the edge ending T+N.
  - busy=0 and the new values are visible from T+N+1.
- stall_md is high in T through T+N whenever ir_d is HI/LO-class. An mfhi issued right behind a mult reaches E in T+N+1 and reads the new value.
- mthi/mtlo take effect at the edge ending their E cycle. md_out reflects the write on the next cycle.
- Back-to-back ops: a second op can start no earlier than T+N+1.

## Configuration
- MD_DIV_EN defined: div/divu are implemented as described above.
- MD_DIV_EN undefined:
  - div/divu decode as no-ops, with start=0, busy unaffected and HI/LO unchanged.
  - They do not trigger stall_md.
  - No divider logic is synthesized.
  - mult/multu and the mfhi/mflo/mthi/mtlo moves are unaffected.

## Test plan
- mult with rs=7, rt=0xFFFFFFFD (-3) at cycle T:
  - busy high T+1..T+5.
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB at T+6.
- multu with rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div with rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles. With MD_DIV_EN undefined: start=0 and hi/lo unchanged.
- Divide by zero:
  - preload hi=0x11111111 via mthi and lo=0x22222222 via mtlo, then div with rt=0.
  - busy lasts 10 cycles.
  - hi/lo are unchanged afterwards.
- mult in E with mflo in D:
  - stall_md=1 for T..T+5.
  - After release, md_out equals the new lo when mflo reaches E.
  - A second mult presented in E during RUN is ignored.
- reset pulsed asynchronously at T+3 of a mult -> hi=0, lo=0, busy=0 immediately, and no commit occurs at T+5.
